// File: rtl/instr_encode_stage.sv
// Packs decoded RV32I fields into 32-bit instruction words and buffers them in a FIFO, each tagged with a byte address.
// Optional macro IMM_RANGE_CHECK_EN also flags immediates that do not fit the encoding format.
module instr_encode_stage #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;
  localparam logic [6:0]  OP_S    = 7'b0100011;
  localparam logic [6:0]  OP_B    = 7'b1100011;
  localparam logic [6:0]  OP_J    = 7'b1101111;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W:0]    CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    CNT_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Returns {unsupported_opcode, word}; immediates are truncated to the format's bit positions.
  function automatic logic [32:0] encode_fields(
    input logic [6:0]  op,
    input logic [4:0]  rd_f,
    input logic [4:0]  rs1_f,
    input logic [4:0]  rs2_f,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [20:0] im
  );
    logic [31:0] word;
    logic        err;
    word = NOP;
    err  = 1'b0;
    case (op)
      OP_R:            word = {f7, rs2_f, rs1_f, f3, rd_f, op};
      OP_IMM, OP_LOAD: word = {im[11:0], rs1_f, f3, rd_f, op};
      OP_S:            word = {im[11:5], rs2_f, rs1_f, f3, im[4:0], op};
      OP_B:            word = {im[12], im[10:5], rs2_f, rs1_f, f3, im[4:1], im[11], op};
      OP_J:            word = {im[20], im[10:1], im[11], im[19:12], rd_f, op};
      default: begin
        word = NOP;
        err  = 1'b1;
      end
    endcase
    return {err, word};
  endfunction

  logic [31:0]       instr_mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_r  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] err_mem_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [ADDR_W-1:0] addr_r;

  logic [31:0] enc_word_s;
  logic        enc_err_s;
  logic        imm_bad_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;

  assign {enc_err_s, enc_word_s} = encode_fields(opcode, rd, rs1, rs2, funct3, funct7, imm[20:0]);

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be the sign extension of the bits the format can hold (and even for branches/jumps).
  always_comb begin
    imm_bad_s = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_S: imm_bad_s = !((&imm[31:11]) || !(|imm[31:11]));
      OP_B:                  imm_bad_s = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      OP_J:                  imm_bad_s = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      default:               imm_bad_s = 1'b0;
    endcase
  end
`else
  logic unused_imm_s;
  assign unused_imm_s = ^imm[31:21];
  assign imm_bad_s    = 1'b0;
`endif

  assign full_s    = (count_r == CNT_FULL);
  assign in_ready  = !full_s && !clear;
  assign out_valid = (count_r != CNT_ZERO);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready && !clear;

  // Head entry is presented only while valid; otherwise outputs read as zero.
  always_comb begin
    if (out_valid) begin
      out_instr = instr_mem_r[rd_ptr_r];
      out_addr  = addr_mem_r[rd_ptr_r];
      out_err   = err_mem_r[rd_ptr_r];
    end else begin
      out_instr = 32'h0000_0000;
      out_addr  = ADDR_ZERO;
      out_err   = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy, address tag counter and accepted-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        addr_mem_r[i]  <= ADDR_ZERO;
      end
      err_mem_r  <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      addr_r     <= BASE_ADDR;
      word_count <= ADDR_ZERO;
    end else if (clear) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      addr_r     <= BASE_ADDR;
      word_count <= ADDR_ZERO;
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= enc_word_s;
        addr_mem_r[wr_ptr_r]  <= addr_r;
        err_mem_r[wr_ptr_r]   <= enc_err_s | imm_bad_s;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
        addr_r                <= addr_r + ADDR_STEP;
        word_count            <= word_count + ADDR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end
    end
  end

endmodule
